// File: rtl/regbank_seq.sv
// Command sequencer for the 16 x 64-bit complex register bank and its external ALU.
// Bank/ALU controls decode combinationally from the FSM state and the latched command.
module regbank_seq #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_op,
  input  logic [3:0]  i_cmd_dst,
  input  logic [3:0]  i_cmd_srcA,
  input  logic [3:0]  i_cmd_srcB,
  input  logic        i_cmd_cA,
  input  logic        i_cmd_cB,
  input  logic [1:0]  i_cmd_endreg,
  input  logic [63:0] i_cmd_data,
  output logic        o_regwe,
  output logic [3:0]  o_selwreg,
  output logic [1:0]  o_endreg,
  output logic [63:0] o_inA,
  output logic [3:0]  o_seloutA,
  output logic [3:0]  o_seloutB,
  output logic        o_cnstA,
  output logic        o_cnstB,
  output logic        o_enrregA,
  output logic        o_enrregB,
  input  logic [63:0] i_outA,
  output logic        o_alu_start,
  output logic [1:0]  o_alu_op,
  input  logic        i_alu_done,
  input  logic [63:0] i_alu_res,
  output logic        o_busy,
  output logic        o_cmd_done,
  output logic        o_err_timeout
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0] OP_NOP = 3'b000, OP_LOAD = 3'b001, OP_SWP = 3'b011;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LAUNCH, S_WAIT, S_WRITE} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  dst;
    logic [3:0]  srca;
    logic [3:0]  srcb;
    logic        ca;
    logic        cb;
    logic [1:0]  endreg;
    logic [63:0] data;
  } cmd_t;

  state_t         r_state, w_nxt;
  cmd_t           r_cmd;
  logic [63:0]    r_res;
  logic [CW-1:0]  r_cnt;
  logic           w_accept, w_alu, w_last;

  assign w_accept = i_cmd_valid && o_cmd_ready;
  assign w_alu    = r_cmd.op[2];
  assign w_last   = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  // Counter is held at 0 outside WAIT so it restarts on every WAIT entry.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cmd <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept)
        r_cmd <= '{op: i_cmd_op, dst: i_cmd_dst, srca: i_cmd_srcA, srcb: i_cmd_srcB,
                   ca: i_cmd_cA, cb: i_cmd_cB, endreg: i_cmd_endreg, data: i_cmd_data};
      if (r_state == S_WAIT && i_alu_done) r_res <= i_alu_res;
      r_cnt <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)
                  w_nxt = (i_cmd_op == OP_NOP || i_cmd_op == OP_LOAD) ? S_WRITE : S_READ;
      S_READ:   w_nxt = w_alu ? S_LAUNCH : S_WRITE;
      S_LAUNCH: w_nxt = S_WAIT;
      S_WAIT:   if (i_alu_done)  w_nxt = S_WRITE;
                else if (w_last) w_nxt = S_IDLE;
      S_WRITE:  w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // Every output is forced low while reset is high, even mid-command.
  always_comb begin
    o_cmd_ready   = 1'b0;
    o_busy        = 1'b0;
    o_regwe       = 1'b0;
    o_selwreg     = '0;
    o_endreg      = '0;
    o_inA         = '0;
    o_seloutA     = '0;
    o_seloutB     = '0;
    o_cnstA       = 1'b0;
    o_cnstB       = 1'b0;
    o_enrregA     = 1'b0;
    o_enrregB     = 1'b0;
    o_alu_start   = 1'b0;
    o_alu_op      = '0;
    o_cmd_done    = 1'b0;
    o_err_timeout = 1'b0;
    if (!i_reset) begin
      if (r_state == S_IDLE) o_cmd_ready = 1'b1;
      else begin
        o_busy    = 1'b1;
        o_alu_op  = w_alu ? r_cmd.op[1:0] : 2'b00;
        o_seloutA = r_cmd.srca;
        o_seloutB = w_alu ? r_cmd.srcb : 4'd0;
      end
      case (r_state)
        S_READ: begin
          o_cnstA   = r_cmd.ca;
          o_enrregA = 1'b1;
          o_cnstB   = w_alu && r_cmd.cb;
          o_enrregB = w_alu;
        end
        S_LAUNCH: o_alu_start = 1'b1;
        S_WAIT:   o_err_timeout = !i_alu_done && w_last;
        S_WRITE: begin
          o_cmd_done = 1'b1;
          o_regwe    = (r_cmd.op != OP_NOP);
          o_selwreg  = r_cmd.dst;
          o_endreg   = (r_cmd.op == OP_SWP) ? 2'b11 : r_cmd.endreg;
          if (w_alu)                     o_inA = r_res;
          else if (r_cmd.op == OP_LOAD)  o_inA = r_cmd.data;
          else if (r_cmd.op != OP_NOP)   o_inA = i_outA;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_regbank_seq.sv
// Bench for regbank_seq: bank model and ALU emulation around the DUT, with a
// command-level reference of register contents and per-command timing.
module tb_regbank_seq;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_dst = '0, cmd_srcA = '0, cmd_srcB = '0;
  logic        cmd_cA = 1'b0, cmd_cB = 1'b0;
  logic [1:0]  cmd_endreg = '0;
  logic [63:0] cmd_data = '0;
  logic        regwe, cnstA, cnstB, enrregA, enrregB, alu_start, busy, cmd_done, err_timeout;
  logic [3:0]  selwreg, seloutA, seloutB;
  logic [1:0]  endreg, alu_op;
  logic [63:0] inA, outA, alu_res = '0;
  logic        alu_done = 1'b0;
  logic        bank_clr = 1'b1;
  logic [63:0] bank [16];
  logic [63:0] ref_r [16];
  int          ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  regbank_seq #(.TIMEOUT(T)) dut (
    .i_clock(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_dst(cmd_dst), .i_cmd_srcA(cmd_srcA), .i_cmd_srcB(cmd_srcB),
    .i_cmd_cA(cmd_cA), .i_cmd_cB(cmd_cB), .i_cmd_endreg(cmd_endreg), .i_cmd_data(cmd_data),
    .o_regwe(regwe), .o_selwreg(selwreg), .o_endreg(endreg), .o_inA(inA),
    .o_seloutA(seloutA), .o_seloutB(seloutB), .o_cnstA(cnstA), .o_cnstB(cnstB),
    .o_enrregA(enrregA), .o_enrregB(enrregB), .i_outA(outA),
    .o_alu_start(alu_start), .o_alu_op(alu_op), .i_alu_done(alu_done), .i_alu_res(alu_res),
    .o_busy(busy), .o_cmd_done(cmd_done), .o_err_timeout(err_timeout));

  function automatic logic [63:0] cval(input logic [3:0] c);
    return (c == 4'b1010) ? 64'h0000_0001_0000_0000 : {60'd0, c};
  endfunction

  // Final-write modes: full, high half, low half, swapped halves.
  function automatic logic [63:0] wr(input logic [63:0] old, input logic [63:0] v, input logic [1:0] m);
    case (m)
      2'b00:   return v;
      2'b01:   return {v[63:32], old[31:0]};
      2'b10:   return {old[63:32], v[31:0]};
      default: return {v[31:0], v[63:32]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
      outA <= '0;
    end else begin
      if (regwe) bank[selwreg] <= wr(bank[selwreg], inA, endreg);
      if (enrregA) outA <= cnstA ? cval(seloutA) : bank[seloutA];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{regwe, selwreg, endreg, inA, seloutA, seloutB, cnstA, cnstB, enrregA, enrregB,
             alu_start, alu_op, busy, cmd_done, err_timeout};
  endfunction

  // Issue one command; d = ALU done delay after LAUNCH (0 = never). Checks timing and
  // write-port contents against the command rules, then updates the reference bank.
  task automatic run(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] sa,
                     input logic [3:0] sb, input logic ca, input logic cb, input logic [1:0] er,
                     input logic [63:0] data, input int d, input logic [63:0] res);
    int rk = 0, dk = 0, dn = 0, wk = 0, wn = 0, sk = 0, sn = 0, ek = 0, en = 0, lowbusy = 0;
    int wr_cyc, exp_rk;
    logic [3:0] wsel = '0;
    logic [1:0] wer = '0, aop = '0;
    logic [63:0] win = '0, val;
    logic [13:0] rd1 = '0, rd_exp;
    logic idle_dirty = 1'b0;
    logic is_alu = op[2];
    logic tmo = op[2] && (d == 0 || d > T);
    logic writes = (op != 3'b000) && !tmo;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srcA = sa; cmd_srcB = sb;
    cmd_cA = ca; cmd_cB = cb; cmd_endreg = er; cmd_data = data;
    #1 chk("ready_at_issue", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      alu_done = (d != 0 && k == 2 + d);
      alu_res  = res;
      #1;
      if (cmd_ready) begin rk = k; idle_dirty = any_out(); break; end
      if (!busy) lowbusy++;
      if (k == 1) rd1 = {enrregA, cnstA, seloutA, enrregB, cnstB, seloutB};
      if (regwe) begin wn++; wk = k; wsel = selwreg; wer = endreg; win = inA; end
      if (cmd_done) begin dn++; dk = k; end
      if (alu_start) begin sn++; sk = k; aop = alu_op; end
      if (err_timeout) begin en++; ek = k; end
    end
    alu_done = 1'b0;
    wr_cyc = (op <= 3'b001) ? 1 : (!is_alu ? 2 : 3 + d);
    exp_rk = tmo ? 3 + T : wr_cyc + 1;
    val = (op == 3'b001) ? data : (is_alu ? res : (ca ? cval(sa) : ref_r[sa]));
    chk("ready_return_cycle", 64'(rk), 64'(exp_rk));
    chk("busy_low_while_active", 64'(lowbusy), 64'd0);
    chk("outputs_zero_in_idle", 64'(idle_dirty), 64'd0);
    chk("cmd_done_count", 64'(dn), tmo ? 64'd0 : 64'd1);
    if (!tmo) chk("cmd_done_cycle", 64'(dk), 64'(wr_cyc));
    chk("regwe_count", 64'(wn), writes ? 64'd1 : 64'd0);
    chk("alu_start_count", 64'(sn), is_alu ? 64'd1 : 64'd0);
    chk("err_timeout_count", 64'(en), tmo ? 64'd1 : 64'd0);
    if (tmo) chk("err_timeout_cycle", 64'(ek), 64'(2 + T));
    if (is_alu) begin
      chk("alu_start_cycle", 64'(sk), 64'd2);
      chk("alu_op", 64'(aop), 64'(op[1:0]));
    end
    if (op >= 3'b010) begin
      rd_exp = {1'b1, ca, sa, is_alu, is_alu & cb, is_alu ? sb : 4'd0};
      chk("read_controls", 64'(rd1), 64'(rd_exp));
    end
    if (writes) begin
      chk("write_cycle", 64'(wk), 64'(wr_cyc));
      chk("selwreg", 64'(wsel), 64'(dst));
      chk("endreg", 64'(wer), (op == 3'b011) ? 64'd3 : 64'(er));
      chk("inA", win, val);
      ref_r[dst] = wr(ref_r[dst], val, (op == 3'b011) ? 2'b11 : er);
    end
  endtask

  initial begin
    logic [2:0] op;
    int d;
    for (int i = 0; i < 16; i++) ref_r[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(cmd_ready), 64'd0);
    chk("reset_outputs", 64'(any_out()), 64'd0);
    bank_clr = 1'b0;
    rst = 1'b0;
    #1 chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    run(3'b001, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 64'h0000_0003_FFFF_FFFE, 0, '0);
    run(3'b011, 4'd6, 4'd5, 4'd0, 1'b0, 1'b0, 2'b00, '0, 0, '0);
    @(negedge clk);
    chk("swp_bank_r6", bank[6], 64'hFFFF_FFFE_0000_0003);
    run(3'b101, 4'd9, 4'd5, 4'd7, 1'b0, 1'b0, 2'b00, '0, 4, 64'h1);
    run(3'b110, 4'd2, 4'd1, 4'd3, 1'b0, 1'b1, 2'b00, '0, 0, 64'hDEAD);
    run(3'b111, 4'd4, 4'd2, 4'd3, 1'b1, 1'b0, 2'b01, '0, T, 64'h1234_5678_9ABC_DEF0);
    run(3'b010, 4'd3, 4'b1010, 4'd0, 1'b1, 1'b0, 2'b00, '0, 0, '0);
    @(negedge clk);
    chk("mov_const_r3", bank[3], 64'h0000_0001_0000_0000);
    run(3'b000, 4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 64'hFFFF, 0, '0);

    // Reset lands while the ALU command sits in WAIT; the late alu_done must be dropped.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b100; cmd_dst = 4'd11; cmd_srcA = 4'd1; cmd_srcB = 4'd2;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("midreset_outputs", 64'(any_out() | cmd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0; alu_done = 1'b1; alu_res = 64'hBAD;
    #1 chk("midreset_ready", 64'(cmd_ready), 64'd1);
    chk("midreset_no_write", 64'(regwe | cmd_done), 64'd0);
    @(negedge clk);
    alu_done = 1'b0;
    #1 chk("stray_done_ignored", 64'(busy | regwe), 64'd0);
    run(3'b001, 4'd11, 4'd0, 4'd0, 1'b0, 1'b0, 2'b10, 64'hAAAA_BBBB_CCCC_DDDD, 0, '0);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      run(op, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
          2'($urandom), {$urandom, $urandom}, d, {$urandom, $urandom});
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++) chk($sformatf("bank_r%0d", i), bank[i], ref_r[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
